// File: rtl/adc_boxcar_filter.sv
// adc_boxcar_filter
// Moving-average (boxcar) filter between a 12-bit ADC AXI-Stream and a
// 14-bit DAC AXI-Stream. One averaged output per accepted input sample.
// Optional build macro: BOXCAR_ROUND_EN (round half-up before truncation).
module adc_boxcar_filter #(
  parameter int LOG2_TAPS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [13:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  input  logic        clear,
  output logic        filled
);

  localparam int TAPS = 1 << LOG2_TAPS;
  localparam int SW   = 12 + LOG2_TAPS;
  localparam int CW   = LOG2_TAPS + 1;
  localparam logic [CW-1:0] FILL_MAX  = CW'(TAPS);
  localparam logic [CW-1:0] FILL_LAST = CW'(TAPS - 1);

`ifdef BOXCAR_ROUND_EN
  // Half of one output LSB, expressed in accumulator units; zero for 4 taps
  // because no bits are discarded there.
  localparam int          RND_SH  = (LOG2_TAPS >= 3) ? (LOG2_TAPS - 3) : 0;
  localparam logic [SW:0] RND_ADD = (LOG2_TAPS >= 3) ?
                                    ((SW+1)'(1) << RND_SH) : (SW+1)'(0);
`endif

  logic [11:0]   r_tap [TAPS];
  logic [SW-1:0] r_acc;
  logic [CW-1:0] r_fill_cnt;
  logic          r_filled;
  logic [13:0]   r_m_data;
  logic          r_m_valid;
  logic          r_rdy_en;

  logic          w_s_ready;
  logic          w_accept;
  logic          w_consume;
  logic [SW-1:0] w_acc_next;
  logic [SW:0]   w_rnd;
  logic [13:0]   w_out;

  // Handshake qualifiers: ready is held low in reset and during a clear cycle.
  always_comb begin
    w_s_ready = r_rdy_en & ~clear & (~r_m_valid | m_axis_tready);
    w_accept  = s_axis_tvalid & w_s_ready;
    w_consume = r_m_valid & m_axis_tready;
  end

  // Running sum update and the scaled output value it produces.
  always_comb begin
    w_acc_next = r_acc + {{LOG2_TAPS{1'b0}}, s_axis_tdata}
                       - {{LOG2_TAPS{1'b0}}, r_tap[TAPS-1]};
`ifdef BOXCAR_ROUND_EN
    w_rnd = {1'b0, w_acc_next} + RND_ADD;
`else
    w_rnd = {1'b0, w_acc_next};
`endif
    // Headroom guarantees the rounded sum never reaches bit SW.
    w_out = w_rnd[SW-1:LOG2_TAPS-2];
  end

  // Ready enable: rises on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
    end
  end

  // Delay line: new sample enters tap[0], oldest falls off tap[TAPS-1].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) r_tap[i] <= 12'd0;
    end else if (clear) begin
      for (int i = 0; i < TAPS; i++) r_tap[i] <= 12'd0;
    end else if (w_accept) begin
      for (int i = TAPS - 1; i > 0; i--) r_tap[i] <= r_tap[i-1];
      r_tap[0] <= s_axis_tdata;
    end else begin
      for (int i = 0; i < TAPS; i++) r_tap[i] <= r_tap[i];
    end
  end

  // Accumulator plus saturating fill counter and the window-full flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_fill_cnt <= '0;
      r_filled   <= 1'b0;
    end else if (clear) begin
      r_acc      <= '0;
      r_fill_cnt <= '0;
      r_filled   <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_acc_next;
      if (r_fill_cnt != FILL_MAX) begin
        r_fill_cnt <= r_fill_cnt + CW'(1);
      end else begin
        r_fill_cnt <= r_fill_cnt;
      end
      r_filled <= r_filled | (r_fill_cnt == FILL_LAST);
    end else begin
      r_acc      <= r_acc;
      r_fill_cnt <= r_fill_cnt;
      r_filled   <= r_filled;
    end
  end

  // Output register: reload on accept, drop valid once consumed, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_data  <= 14'd0;
      r_m_valid <= 1'b0;
    end else if (clear) begin
      r_m_data  <= 14'd0;
      r_m_valid <= 1'b0;
    end else if (w_accept) begin
      r_m_data  <= w_out;
      r_m_valid <= 1'b1;
    end else if (w_consume) begin
      r_m_data  <= r_m_data;
      r_m_valid <= 1'b0;
    end else begin
      r_m_data  <= r_m_data;
      r_m_valid <= r_m_valid;
    end
  end

  assign s_axis_tready = w_s_ready;
  assign m_axis_tdata  = r_m_data;
  assign m_axis_tvalid = r_m_valid;
  assign filled        = r_filled;

endmodule

// File: tb/tb_adc_boxcar_filter.sv
// Self-checking bench for adc_boxcar_filter: vector table for ramp/step,
// directed reset/clear/backpressure sequences, and a window-sum scoreboard.
module tb_adc_boxcar_filter;

  logic        clk;
  logic        rst_n;
  logic [11:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [13:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        clear;
  logic        filled;

  // second instance for the 16-tap rounding check
  logic [11:0] s1_data;
  logic        s1_valid;
  logic        s1_ready;
  logic [13:0] m1_data;
  logic        m1_valid;
  logic        m1_ready;
  logic        clear1;
  logic        filled1;

  int total = 0;
  int bad   = 0;

  adc_boxcar_filter #(.LOG2_TAPS(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
    .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
    .clear(clear), .filled(filled)
  );

  adc_boxcar_filter #(.LOG2_TAPS(4)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s1_data), .s_axis_tvalid(s1_valid), .s_axis_tready(s1_ready),
    .m_axis_tdata(m1_data), .m_axis_tvalid(m1_valid), .m_axis_tready(m1_ready),
    .clear(clear1), .filled(filled1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard (only this block writes the queues) --------
  int q_exp[$];
  int q_act[$];
  int mdl_tap[8];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mdl_tap[i] = 0;
    end else begin
      if (m_valid && m_ready) q_act.push_back(int'(m_data));
      if (clear) begin
        if (m_valid && !m_ready) void'(q_exp.pop_back());
        for (int i = 0; i < 8; i++) mdl_tap[i] = 0;
      end else if (s_valid && s_ready) begin
        int sum;
        for (int i = 7; i > 0; i--) mdl_tap[i] = mdl_tap[i-1];
        mdl_tap[0] = int'(s_data);
        sum = 0;
        for (int i = 0; i < 8; i++) sum += mdl_tap[i];
`ifdef BOXCAR_ROUND_EN
        q_exp.push_back((sum + 1) >> 1);
`else
        q_exp.push_back(sum >> 1);
`endif
      end
    end
  end

  // ---------------- helpers --------------------------------------------
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  int rd_idx = 0;
  task automatic drain();
    while (rd_idx < q_act.size() && rd_idx < q_exp.size()) begin
      chk($sformatf("sb_out[%0d]", rd_idx), q_act[rd_idx], q_exp[rd_idx]);
      rd_idx++;
    end
  endtask

  logic rand_rdy = 1'b0;

  // called just after a falling edge; returns just after the falling edge
  // that follows the accepting rising edge
  task automatic send(input logic [11:0] d);
    logic ok;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (rand_rdy) m_ready = 1'($urandom_range(0, 1));
      #1;
      ok = s_ready;
      @(negedge clk);
    end
    s_valid = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  typedef struct {
    logic [11:0] d;
    int          exp_data;
    logic        exp_filled;
  } vec_t;
  vec_t tbl[24];

  // ---------------- main sequence --------------------------------------
  initial begin
    int ramp_trunc[8];
    int ramp_round[8];
    ramp_trunc = '{2047, 4095, 6142, 8190, 10237, 12285, 14332, 16380};
    ramp_round = '{2048, 4095, 6143, 8190, 10238, 12285, 14333, 16380};
    for (int k = 0; k < 8; k++) begin
      tbl[k].d = 12'hFFF;
`ifdef BOXCAR_ROUND_EN
      tbl[k].exp_data = ramp_round[k];
`else
      tbl[k].exp_data = ramp_trunc[k];
`endif
      tbl[k].exp_filled = (k == 7);
    end
    for (int k = 0; k < 8; k++) begin
      tbl[8+k].d          = 12'h800;
      tbl[8+k].exp_data   = (k + 1) * 1024;
      tbl[8+k].exp_filled = (k == 7);
      tbl[16+k].d          = 12'h000;
      tbl[16+k].exp_data   = 7168 - k * 1024;
      tbl[16+k].exp_filled = 1'b1;
    end

    // reset with valid input presented
    rst_n = 1'b0; clear = 1'b0; m_ready = 1'b1;
    s_valid = 1'b1; s_data = 12'hABC;
    clear1 = 1'b0; m1_ready = 1'b1; s1_valid = 1'b1; s1_data = 12'h002;
    #1;
    chk("rst_s_ready", int'(s_ready), 0);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_data",  int'(m_data), 0);
    chk("rst_filled",  int'(filled), 0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold_s_ready", int'(s_ready), 0);
    s_valid = 1'b0; s1_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_s_ready", int'(s_ready), 1);
    chk("post_rst_m_data",  int'(m_data), 0);
    chk("post_rst_m_valid", int'(m_valid), 0);

    // 16-tap rounding: a single sample of 2
    s1_valid = 1'b1; s1_data = 12'h002;
    @(negedge clk);
    s1_valid = 1'b0;
    chk("r16_valid", int'(m1_valid), 1);
`ifdef BOXCAR_ROUND_EN
    chk("r16_data", int'(m1_data), 1);
`else
    chk("r16_data", int'(m1_data), 0);
`endif

    // full-scale ramp
    for (int k = 0; k < 8; k++) begin
      send(tbl[k].d);
      chk($sformatf("ramp_valid[%0d]", k),  int'(m_valid), 1);
      chk($sformatf("ramp_data[%0d]", k),   int'(m_data), tbl[k].exp_data);
      chk($sformatf("ramp_filled[%0d]", k), int'(filled), int'(tbl[k].exp_filled));
    end

    // clear colliding with a valid sample
    clear = 1'b1; s_valid = 1'b1; s_data = 12'h123;
    #1;
    chk("clr_s_ready", int'(s_ready), 0);
    @(negedge clk);
    clear = 1'b0; s_valid = 1'b0;
    chk("clr_m_valid", int'(m_valid), 0);
    chk("clr_m_data",  int'(m_data), 0);
    chk("clr_filled",  int'(filled), 0);

    // step response (first entry doubles as the post-clear 0x800 -> 1024)
    for (int k = 8; k < 24; k++) begin
      send(tbl[k].d);
      chk($sformatf("step_valid[%0d]", k),  int'(m_valid), 1);
      chk($sformatf("step_data[%0d]", k),   int'(m_data), tbl[k].exp_data);
      chk($sformatf("step_filled[%0d]", k), int'(filled), int'(tbl[k].exp_filled));
    end
    drain();

    // backpressure: 5 stalled cycles mid-stream
    send(12'h3A5);
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 12'h7C1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp_s_ready[%0d]", k), int'(s_ready), 0);
      chk($sformatf("bp_m_valid[%0d]", k), int'(m_valid), 1);
      chk($sformatf("bp_m_data[%0d]", k),  int'(m_data), q_exp[$]);
      @(negedge clk);
    end
    m_ready = 1'b1;
    send(12'h7C1);
    for (int k = 0; k < 6; k++) send(12'($urandom_range(0, 4095)));

    // random ready toggling
    rand_rdy = 1'b1;
    for (int k = 0; k < 12; k++) send(12'($urandom_range(0, 4095)));
    rand_rdy = 1'b0;
    m_ready = 1'b1;

    // clear while an output is stalled: pending output is dropped
    send(12'h456);
    m_ready = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; m_ready = 1'b1;
    chk("clr_drop_m_valid", int'(m_valid), 0);
    send(12'h800);
    chk("clr_drop_next", int'(m_data), 1024);

    repeat (3) @(negedge clk);
    drain();
    chk("sb_count", q_act.size(), q_exp.size());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
